// File: rtl/dmem_access_ctrl_pkg.sv
// Shared data-bus types, access sizes and FSM states for the MEM-stage access controller.
// Address alignment helpers live here so the controller and any bus model agree on them.
package dmem_access_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    u64      addr;
    msize_t  size;
    strobe_t strobe;
    u64      data;
  } dbus_req_t;

  typedef struct packed {
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Byte-offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input msize_t size);
    logic [2:0] m;
    case (size)
      MSIZE1:  m = 3'b000;
      MSIZE2:  m = 3'b001;
      MSIZE4:  m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic u64 align_addr(input u64 addr, input msize_t size);
    return {addr[63:3], addr[2:0] & ~align_mask(size)};
  endfunction

  function automatic logic is_misaligned(input u64 addr, input msize_t size);
    return |(addr[2:0] & align_mask(size));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_mem_lane_align.sv
// mem_lane_align: combinational byte-lane placement for stores and
// lane extraction plus sign/zero extension for loads on a 64-bit bus.
module mem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0] st_off_i,
  input  msize_t     st_size_i,
  input  u64         st_wdata_i,
  output strobe_t    st_strobe_o,
  output u64         st_data_o,
  input  logic [2:0] ld_off_i,
  input  msize_t     ld_size_i,
  input  logic       ld_unsigned_i,
  input  u64         ld_rdata_i,
  output u64         ld_data_o
);

  strobe_t st_base;
  u64      st_masked;
  u64      ld_shifted;

  // Store data arrives right-justified; anything above the access width is dropped
  // so unused lanes go out as zero.
  always_comb begin
    st_base   = 8'h00;
    st_masked = '0;
    case (st_size_i)
      MSIZE1: begin
        st_base   = 8'h01;
        st_masked = {56'd0, st_wdata_i[7:0]};
      end
      MSIZE2: begin
        st_base   = 8'h03;
        st_masked = {48'd0, st_wdata_i[15:0]};
      end
      MSIZE4: begin
        st_base   = 8'h0F;
        st_masked = {32'd0, st_wdata_i[31:0]};
      end
      default: begin
        st_base   = 8'hFF;
        st_masked = st_wdata_i;
      end
    endcase
  end

  assign st_strobe_o = st_base << st_off_i;
  assign st_data_o   = st_masked << {st_off_i, 3'b000};

  assign ld_shifted  = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_shifted;
    case (ld_size_i)
      MSIZE1: ld_data_o = ld_unsigned_i ? {56'd0, ld_shifted[7:0]}
                                        : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      MSIZE2: ld_data_o = ld_unsigned_i ? {48'd0, ld_shifted[15:0]}
                                        : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      MSIZE4: ld_data_o = ld_unsigned_i ? {32'd0, ld_shifted[31:0]}
                                        : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one MEM-stage load/store at a time onto the data bus.
// Define DMEM_MISALIGN_EXC_EN to reject misaligned accesses (misalign pulse) instead of force-aligning them.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic       req_store,
  input  u64         req_addr,
  input  msize_t     req_msize,
  input  logic       req_unsigned,
  input  u64         req_wdata,
  input  logic       flush,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       resp_valid,
  output u64         resp_rdata,
  output logic       stall,
  output logic       misalign
);

  dmem_state_t state_q, state_d;
  dbus_req_t   dreq_q, dreq_d;
  logic        store_q, store_d;
  logic        unsigned_q, unsigned_d;
  logic        flushed_q, flushed_d;
  u64          rdata_q, rdata_d;

  u64          issue_addr;
  strobe_t     lane_strobe;
  u64          lane_data;
  u64          ld_ext;
  logic        req_misal;

  assign issue_addr = align_addr(req_addr, req_msize);

  // Store path works on the incoming request; load path on the held bus request.
  mem_lane_align u_lane (
    .st_off_i      (issue_addr[2:0]),
    .st_size_i     (req_msize),
    .st_wdata_i    (req_wdata),
    .st_strobe_o   (lane_strobe),
    .st_data_o     (lane_data),
    .ld_off_i      (dreq_q.addr[2:0]),
    .ld_size_i     (dreq_q.size),
    .ld_unsigned_i (unsigned_q),
    .ld_rdata_i    (dresp.data),
    .ld_data_o     (ld_ext)
  );

`ifdef DMEM_MISALIGN_EXC_EN
  assign req_misal = is_misaligned(req_addr, req_msize);
`else
  assign req_misal = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dreq_d     = dreq_q;
    store_d    = store_q;
    unsigned_d = unsigned_q;
    flushed_d  = flushed_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          store_d    = req_store;
          unsigned_d = req_unsigned;
          flushed_d  = 1'b0;
          rdata_d    = '0;
          if (req_misal) begin
            state_d = DONE;
          end else begin
            state_d       = BUSY;
            dreq_d.valid  = 1'b1;
            dreq_d.addr   = issue_addr;
            dreq_d.size   = req_msize;
            dreq_d.strobe = req_store ? lane_strobe : 8'h00;
            dreq_d.data   = req_store ? lane_data : '0;
          end
        end
      end
      BUSY: begin
        // A flush never aborts the bus op; it only marks the result for discard.
        if (flush) flushed_d = 1'b1;
        if (dresp.data_ok) begin
          dreq_d.valid = 1'b0;
          rdata_d      = store_q ? '0 : ld_ext;
          state_d      = (flushed_q || flush) ? IDLE : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dreq_q     <= '0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      flushed_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      dreq_q     <= dreq_d;
      store_q    <= store_d;
      unsigned_q <= unsigned_d;
      flushed_q  <= flushed_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef DMEM_MISALIGN_EXC_EN
  logic misal_q;

  // Tracks the request seen while idle; DONE is only reached from IDLE via a misaligned accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misal_q <= 1'b0;
    end else if (state_q == IDLE) begin
      misal_q <= req_misal;
    end
  end

  assign misalign = (state_q == DONE) && misal_q && !flush;
`else
  assign misalign = 1'b0;
`endif

  assign dreq       = dreq_q;
  assign resp_rdata = rdata_q;
  assign resp_valid = (state_q == DONE) && !flush;
  assign stall      = req_valid && !resp_valid && !misalign;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed table-driven bench for dmem_access_ctrl plus hand sequences for flush/reset/misalign.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_store, req_unsigned, flush;
  u64         req_addr, req_wdata;
  msize_t     req_msize;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       resp_valid, stall, misalign;
  u64         resp_rdata;

  int    n_vec = 0;
  int    n_bad = 0;
  string ctx   = "init";

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_store    (req_store),
    .req_addr     (req_addr),
    .req_msize    (req_msize),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .dreq         (dreq),
    .dresp        (dresp),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .stall        (stall),
    .misalign     (misalign)
  );

  typedef struct {
    logic    st;
    u64      addr;
    msize_t  sz;
    logic    uns;
    u64      wdata;
    u64      rdata;
    int      lat;
    u64      e_addr;
    strobe_t e_strb;
    u64      e_data;
    u64      e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", ctx, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input u64 addr, input msize_t sz, input logic uns, input u64 wd);
    req_valid    = 1'b1;
    req_store    = st;
    req_addr     = addr;
    req_msize    = sz;
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  function automatic vec_t mk(input logic st, input u64 addr, input msize_t sz, input logic uns,
                              input u64 wd, input u64 rd, input int lat, input u64 ea,
                              input strobe_t es, input u64 ed, input u64 er);
    vec_t v;
    v.st = st; v.addr = addr; v.sz = sz; v.uns = uns; v.wdata = wd; v.rdata = rd; v.lat = lat;
    v.e_addr = ea; v.e_strb = es; v.e_data = ed; v.e_rdata = er;
    return v;
  endfunction

  // Starts at posedge+1 with the FSM idle; ends at posedge+1 back in IDLE.
  task automatic run_vec(input vec_t v);
    drive(v.st, v.addr, v.sz, v.uns, v.wdata);
    dresp = '0;
    #1;
    chk("accept_valid", dreq.valid, 0);
    chk("accept_stall", stall, 1);
    tick();
    for (int c = 1; c <= v.lat; c++) begin
      dresp.data_ok = (c == v.lat);
      dresp.data    = (c == v.lat) ? v.rdata : 64'hA5A5_A5A5_A5A5_A5A5;
      #1;
      chk("busy_valid", dreq.valid, 1);
      chk("busy_addr", dreq.addr, v.e_addr);
      chk("busy_size", dreq.size, v.sz);
      chk("busy_strobe", dreq.strobe, v.e_strb);
      chk("busy_data", dreq.data, v.e_data);
      chk("busy_stall", stall, 1);
      chk("busy_resp", resp_valid, 0);
      tick();
    end
    dresp = '0;
    #1;
    chk("done_resp", resp_valid, 1);
    chk("done_rdata", resp_rdata, v.e_rdata);
    chk("done_stall", stall, 0);
    chk("done_valid", dreq.valid, 0);
    req_valid = 1'b0;
    tick();
    chk("after_resp", resp_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_unsigned = 1'b0; flush = 1'b0;
    req_addr = '0; req_wdata = '0; req_msize = MSIZE1; dresp = '0;

    vecs.push_back(mk(1, 64'h1003, MSIZE1, 0, 64'hAB, 0, 3, 64'h1003, 8'h08, 64'hAB00_0000, 0));
    vecs.push_back(mk(0, 64'h2006, MSIZE2, 0, 0, 64'h8001_0000_0000_0000, 2, 64'h2006, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001));
    vecs.push_back(mk(0, 64'h2006, MSIZE2, 1, 0, 64'h8001_0000_0000_0000, 2, 64'h2006, 8'h00, 0, 64'h8001));
    vecs.push_back(mk(0, 64'h3000, MSIZE8, 0, 0, 64'h0123_4567_89AB_CDEF, 1, 64'h3000, 8'h00, 0, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(1, 64'h1004, MSIZE4, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 2, 64'h1004, 8'hF0, 64'hCAFE_F00D_0000_0000, 0));
    vecs.push_back(mk(1, 64'h0012, MSIZE2, 0, 64'h1111_2222_3333_BEEF, 0, 1, 64'h0012, 8'h0C, 64'hBEEF_0000, 0));
    vecs.push_back(mk(0, 64'h0105, MSIZE1, 0, 0, 64'h0000_9A00_0000_0000, 1, 64'h0105, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF9A));
    vecs.push_back(mk(0, 64'h0105, MSIZE1, 1, 0, 64'h0000_9A00_0000_0000, 2, 64'h0105, 8'h00, 0, 64'h9A));
    vecs.push_back(mk(0, 64'h4004, MSIZE4, 0, 0, 64'h8765_4321_0000_0000, 1, 64'h4004, 8'h00, 0, 64'hFFFF_FFFF_8765_4321));
    vecs.push_back(mk(0, 64'h4000, MSIZE4, 1, 0, 64'h0000_0000_F000_0001, 3, 64'h4000, 8'h00, 0, 64'hF000_0001));
    vecs.push_back(mk(1, 64'h5000, MSIZE8, 0, 64'h0123_4567_89AB_CDEF, 0, 1, 64'h5000, 8'hFF, 64'h0123_4567_89AB_CDEF, 0));
`ifndef DMEM_MISALIGN_EXC_EN
    vecs.push_back(mk(1, 64'h1002, MSIZE4, 0, 64'h9999_8888_1122_3344, 0, 1, 64'h1000, 8'h0F, 64'h1122_3344, 0));
    vecs.push_back(mk(0, 64'h2007, MSIZE2, 0, 0, 64'h8001_0000_0000_0000, 1, 64'h2006, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001));
`endif

    // Reset values
    ctx = "reset";
    repeat (2) @(posedge clk);
    #1;
    chk("dreq_valid", dreq.valid, 0);
    chk("dreq_strobe", dreq.strobe, 0);
    chk("dreq_data", dreq.data, 0);
    chk("resp_valid", resp_valid, 0);
    chk("resp_rdata", resp_rdata, 0);
    chk("misalign", misalign, 0);
    #3 reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      ctx = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Flush while BUSY: bus op completes, result dropped, FSM back to IDLE.
    ctx = "flush_busy";
    drive(1, 64'h1008, MSIZE4, 0, 64'h5566_7788);
    tick();
    chk("b1_valid", dreq.valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("b2_valid", dreq.valid, 1);
    chk("b2_strobe", dreq.strobe, 8'h0F);
    chk("b2_data", dreq.data, 64'h5566_7788);
    dresp.data_ok = 1'b1;
    tick();
    dresp = '0;
    #1;
    chk("post_valid", dreq.valid, 0);
    chk("post_resp", resp_valid, 0);
    tick();
    chk("post2_resp", resp_valid, 0);
    drive(0, 64'h1010, MSIZE4, 1, 0);
    tick();
    chk("reissue_valid", dreq.valid, 1);
    chk("reissue_addr", dreq.addr, 64'h1010);
    dresp.data_ok = 1'b1; dresp.data = 64'h1234_5678;
    tick();
    dresp = '0;
    #1;
    chk("reissue_resp", resp_valid, 1);
    chk("reissue_rdata", resp_rdata, 64'h1234_5678);
    req_valid = 1'b0;
    tick();

    // Flush coincident with data_ok behaves as flush-in-BUSY.
    ctx = "flush_ok";
    drive(0, 64'h2000, MSIZE8, 0, 0);
    tick();
    flush = 1'b1; dresp.data_ok = 1'b1; dresp.data = 64'h77;
    tick();
    flush = 1'b0; dresp = '0; req_valid = 1'b0;
    #1;
    chk("resp", resp_valid, 0);
    chk("valid", dreq.valid, 0);
    tick();
    chk("resp2", resp_valid, 0);

    // Flush during DONE suppresses resp_valid.
    ctx = "flush_done";
    drive(0, 64'h2000, MSIZE8, 0, 0);
    tick();
    dresp.data_ok = 1'b1; dresp.data = 64'h66;
    tick();
    dresp = '0;
    flush = 1'b1;
    #1;
    chk("resp", resp_valid, 0);
    flush = 1'b0; req_valid = 1'b0;
    tick();
    chk("resp_idle", resp_valid, 0);

    // Flush in IDLE: nothing issued.
    ctx = "flush_idle";
    drive(1, 64'h3000, MSIZE8, 0, 64'h1);
    flush = 1'b1;
    tick();
    chk("c1_valid", dreq.valid, 0);
    tick();
    chk("c2_valid", dreq.valid, 0);
    flush = 1'b0; req_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a bus op.
    ctx = "reset_busy";
    drive(1, 64'h5000, MSIZE8, 0, 64'hFFFF_0000_FFFF_0000);
    tick();
    chk("pre_valid", dreq.valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("dreq_valid", dreq.valid, 0);
    chk("dreq_strobe", dreq.strobe, 0);
    chk("dreq_data", dreq.data, 0);
    chk("resp_valid", resp_valid, 0);
    chk("resp_rdata", resp_rdata, 0);
    chk("misalign", misalign, 0);
    req_valid = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    run_vec(vecs[3]);

`ifdef DMEM_MISALIGN_EXC_EN
    ctx = "misalign";
    drive(1, 64'h1002, MSIZE4, 0, 64'h1122_3344);
    #1;
    chk("accept_valid", dreq.valid, 0);
    tick();
    chk("done_valid", dreq.valid, 0);
    chk("done_misalign", misalign, 1);
    chk("done_resp", resp_valid, 1);
    chk("done_stall", stall, 0);
    req_valid = 1'b0;
    tick();
    chk("after_misalign", misalign, 0);
    chk("after_valid", dreq.valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test required finish before 200000");
    $fatal(1);
  end

endmodule
